upec_miter_cmp: RTL and testbench

Parametrised N-way miter comparator for UPEC-style formal and simulation checks on Earlgrey. Accepts one observation stream per chip instance, aligns the streams through per-instance FIFOs, and compares them word-by-word under a care mask. On the first divergence it latches the failing instance, the comparison index and the mismatch bits. It sits in the top-level verification wrapper alongside the N `top_earlgrey` instances it observes.

---
 rtl/upec_miter_pkg.sv | 22 ++
 rtl/upec_align_fifo.sv | 52 +++++
 rtl/upec_miter_cmp.sv | 159 +++++++++++++++
 tb/tb_upec_miter_cmp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upec_miter_pkg.sv
// Shared types and helpers for the UPEC miter comparator: state encoding and
// the failing-instance index width.
package upec_miter_pkg;

  localparam logic [1:0] StIdleEnc     = 2'd0;
  localparam logic [1:0] StCheckEnc    = 2'd1;
  localparam logic [1:0] StDivergedEnc = 2'd2;
  localparam logic [1:0] StErrorEnc    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = StIdleEnc,
    ST_CHECK    = StCheckEnc,
    ST_DIVERGED = StDivergedEnc,
    ST_ERROR    = StErrorEnc
  } miter_state_e;

  // A single instance index still needs one bit so the port never collapses.
  function automatic int idx_w(input int num_inst);
    return (num_inst > 1) ? $clog2(num_inst) : 1;
  endfunction

endpackage

// File: rtl/upec_align_fifo.sv
// Per-instance alignment FIFO. Pointers carry one extra wrap bit so full and
// empty fall straight out of the registered pointers.
module upec_align_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [Width-1:0] mem [Depth];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_o  = mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrOne;
      if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/upec_miter_cmp.sv
// N-way miter comparator: aligns per-instance observation streams and latches
// the first masked divergence. Optional trace capture: UPEC_MITER_TRACE_EN.
module upec_miter_cmp
  import upec_miter_pkg::*;
#(
  parameter int NumInst = 2,
  parameter int Width   = 32,
  parameter int Depth   = 4,
  parameter int CntW    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        arm_i,
  input  logic                        clear_i,
  input  logic [NumInst-1:0]          obs_valid_i,
  input  logic [NumInst*Width-1:0]    obs_i,
  input  logic [Width-1:0]            care_mask_i,
  output logic [1:0]                  state_o,
  output logic                        diverged_o,
  output logic                        overflow_o,
  output logic [idx_w(NumInst)-1:0]   fail_idx_o,
  output logic [CntW-1:0]             fail_cycle_o,
  output logic [Width-1:0]            fail_mask_o,
  output logic [CntW-1:0]             cmp_cnt_o,
  output logic [Width-1:0]            trace_ref_o,
  output logic [Width-1:0]            trace_dut_o
);

  localparam int IdxW = idx_w(NumInst);

  miter_state_e      state_q;
  miter_state_e      state_d;
  logic              in_check;
  logic              pop;
  logic              mismatch;
  logic              overflow_ev;
  logic [NumInst-1:0] push;
  logic [NumInst-1:0] empty;
  logic [NumInst-1:0] full;
  logic [Width-1:0]  head [NumInst];
  logic [Width-1:0]  diff_or;
  logic [IdxW-1:0]   diff_idx;

  for (genvar g = 0; g < NumInst; g++) begin : g_fifo
    upec_align_fifo #(
      .Width (Width),
      .Depth (Depth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (clear_i),
      .push_i  (push[g]),
      .data_i  (obs_i[g*Width +: Width]),
      .pop_i   (pop),
      .head_o  (head[g]),
      .empty_o (empty[g]),
      .full_o  (full[g])
    );
  end

  // Walk downwards so the lowest mismatching instance is the one that sticks.
  always_comb begin : p_cmp
    logic [Width-1:0] d;
    d        = '0;
    diff_or  = '0;
    diff_idx = '0;
    for (int k = NumInst - 1; k >= 1; k--) begin
      d       = (head[k] ^ head[0]) & care_mask_i;
      diff_or = diff_or | d;
      if (|d) diff_idx = IdxW'(k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (arm_i) state_d = ST_CHECK;
        ST_CHECK: begin
          if (overflow_ev)   state_d = ST_ERROR;
          else if (mismatch) state_d = ST_DIVERGED;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  // Pushes and pops only exist while checking; terminal states freeze the FIFOs.
  always_comb begin
    in_check    = (state_q == ST_CHECK);
    push        = in_check ? obs_valid_i : '0;
    pop         = in_check && (&(~empty));
    mismatch    = pop && (|diff_or);
    overflow_ev = in_check && !pop && (|(push & full));
    state_o     = state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      diverged_o   <= 1'b0;
      overflow_o   <= 1'b0;
      fail_idx_o   <= '0;
      fail_cycle_o <= '0;
      fail_mask_o  <= '0;
      cmp_cnt_o    <= '0;
    end else if (clear_i) begin
      diverged_o   <= 1'b0;
      overflow_o   <= 1'b0;
      fail_idx_o   <= '0;
      fail_cycle_o <= '0;
      fail_mask_o  <= '0;
      cmp_cnt_o    <= '0;
    end else begin
      if (pop && (cmp_cnt_o != '1)) cmp_cnt_o <= cmp_cnt_o + CntW'(1);
      if (mismatch) begin
        diverged_o   <= 1'b1;
        fail_idx_o   <= diff_idx;
        fail_cycle_o <= cmp_cnt_o;
        fail_mask_o  <= diff_or;
      end
      if (overflow_ev) overflow_o <= 1'b1;
    end
  end

`ifdef UPEC_MITER_TRACE_EN
  logic [Width-1:0] fail_word;

  always_comb begin
    fail_word = head[0];
    for (int k = NumInst - 1; k >= 1; k--) begin
      if (|((head[k] ^ head[0]) & care_mask_i)) fail_word = head[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trace_ref_o <= '0;
      trace_dut_o <= '0;
    end else if (clear_i) begin
      trace_ref_o <= '0;
      trace_dut_o <= '0;
    end else if (mismatch) begin
      trace_ref_o <= head[0];
      trace_dut_o <= fail_word;
    end
  end
`else
  assign trace_ref_o = '0;
  assign trace_dut_o = '0;
`endif

endmodule

// File: tb/tb_upec_miter_cmp.sv
// Bench for upec_miter_cmp: table of stream scenarios plus hand sequences for
// clear/arm interplay, idle push suppression and asynchronous reset.
module tb_upec_miter_cmp;
  import upec_miter_pkg::*;

  localparam int NI = 3;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              arm;
  logic              clear;
  logic [NI-1:0]     obs_valid;
  logic [NI*W-1:0]   obs;
  logic [W-1:0]      care_mask;
  logic [1:0]        state;
  logic              diverged;
  logic              overflow;
  logic [IW-1:0]     fail_idx;
  logic [CW-1:0]     fail_cycle;
  logic [W-1:0]      fail_mask;
  logic [CW-1:0]     cmp_cnt;
  logic [W-1:0]      trace_ref;
  logic [W-1:0]      trace_dut;

  always #5 clk = ~clk;

  upec_miter_cmp #(
    .NumInst (NI),
    .Width   (W),
    .Depth   (D),
    .CntW    (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .arm_i        (arm),
    .clear_i      (clear),
    .obs_valid_i  (obs_valid),
    .obs_i        (obs),
    .care_mask_i  (care_mask),
    .state_o      (state),
    .diverged_o   (diverged),
    .overflow_o   (overflow),
    .fail_idx_o   (fail_idx),
    .fail_cycle_o (fail_cycle),
    .fail_mask_o  (fail_mask),
    .cmp_cnt_o    (cmp_cnt),
    .trace_ref_o  (trace_ref),
    .trace_dut_o  (trace_dut)
  );

  typedef struct {
    string       name;
    logic [2:0]  act;
    int          skew1;
    int          n;
    logic [7:0]  base;
    logic        bad2;
    logic [7:0]  mask;
    logic [1:0]  e_state;
    logic        e_div;
    logic        e_ovf;
    logic [3:0]  e_cnt;
    logic [1:0]  e_idx;
    logic [3:0]  e_fcyc;
    logic [7:0]  e_fmask;
    logic [7:0]  e_tref;
    logic [7:0]  e_tdut;
  } vec_t;

  int             n_cmp = 0;
  int             n_bad = 0;
  logic [CW-1:0]  exp_q[$];
  logic [CW-1:0]  mon_last = '0;
  logic [CW-1:0]  last_exp;
  int             cnt_k[NI];
  bit             model_on = 1'b0;
  vec_t           vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) cnt_k[k] = 0;
    last_exp = '0;
    model_on = 1'b1;
  endtask

  // Each completed alignment across all instances is one expected comparison.
  task automatic push_cycle(input logic [2:0] v, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2);
    int m;
    obs_valid = v;
    obs       = {w2, w1, w0};
    if (model_on) begin
      for (int k = 0; k < NI; k++) if (v[k]) cnt_k[k]++;
      m = cnt_k[0];
      for (int k = 1; k < NI; k++) if (cnt_k[k] < m) m = cnt_k[k];
      if (m > 15) m = 15;
      if (CW'(m) != last_exp) begin
        exp_q.push_back(CW'(m));
        last_exp = CW'(m);
      end
    end
    tick();
    obs_valid = '0;
  endtask

  task automatic begin_run(input bit do_clear);
    model_on = 1'b0;
    if (do_clear) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string nm);
    obs_valid = '0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check({nm, ".drain"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic check_status(input string nm, input logic [1:0] e_state, input logic e_div,
                              input logic e_ovf, input logic [3:0] e_cnt, input logic [1:0] e_idx,
                              input logic [3:0] e_fcyc, input logic [7:0] e_fmask,
                              input logic [7:0] e_tref, input logic [7:0] e_tdut);
    logic [7:0] tr;
    logic [7:0] td;
`ifdef UPEC_MITER_TRACE_EN
    tr = e_tref;
    td = e_tdut;
`else
    tr = 8'h00;
    td = 8'h00;
`endif
    check({nm, ".state"},      32'(state),      32'(e_state));
    check({nm, ".diverged"},   32'(diverged),   32'(e_div));
    check({nm, ".overflow"},   32'(overflow),   32'(e_ovf));
    check({nm, ".cmp_cnt"},    32'(cmp_cnt),    32'(e_cnt));
    check({nm, ".fail_idx"},   32'(fail_idx),   32'(e_idx));
    check({nm, ".fail_cycle"}, 32'(fail_cycle), 32'(e_fcyc));
    check({nm, ".fail_mask"},  32'(fail_mask),  32'(e_fmask));
    check({nm, ".trace_ref"},  32'(trace_ref),  32'(tr));
    check({nm, ".trace_dut"},  32'(trace_dut),  32'(td));
  endtask

  // Scoreboard side: every step of the comparison counter must match the queue.
  always @(negedge clk) begin
    if (cmp_cnt != mon_last) begin
      if (cmp_cnt != '0) begin
        if (exp_q.size() == 0) begin
          check("sb.unexpected_cmp", 32'(cmp_cnt), 32'(mon_last));
        end else begin
          check("sb.cmp_cnt", 32'(cmp_cnt), 32'(exp_q.pop_front()));
        end
      end
      mon_last = cmp_cnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"lockstep", 3'b111, 0, 10, 8'h00, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b0, 4'd10, 2'd0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{"skew",     3'b111, 3, 10, 8'h10, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b0, 4'd10, 2'd0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{"mismatch", 3'b111, 0, 4,  8'hA1, 1'b1, 8'hFF, 2'd2, 1'b1, 1'b0, 4'd4,  2'd2, 4'd3, 8'h01, 8'hA4, 8'hA5};
    vecs[3] = '{"masked",   3'b111, 0, 4,  8'hA1, 1'b1, 8'hFE, 2'd1, 1'b0, 1'b0, 4'd4,  2'd0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{"overflow", 3'b001, 0, 5,  8'h30, 1'b0, 8'hFF, 2'd3, 1'b0, 1'b1, 4'd0,  2'd0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{"saturate", 3'b111, 0, 20, 8'h40, 1'b0, 8'hFF, 2'd1, 1'b0, 1'b0, 4'd15, 2'd0, 4'd0, 8'h00, 8'h00, 8'h00};

    rst_n     = 1'b0;
    arm       = 1'b0;
    clear     = 1'b0;
    obs_valid = '0;
    obs       = '0;
    care_mask = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_status("reset", 2'd0, 1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();

    // Words offered in IDLE must never reach the FIFOs.
    push_cycle(3'b111, 8'h11, 8'h22, 8'h33);
    push_cycle(3'b111, 8'h44, 8'h55, 8'h66);
    check("idle.state", 32'(state), 32'd0);
    begin_run(1'b0);
    push_cycle(3'b111, 8'h05, 8'h05, 8'h05);
    drain("idle_push");
    check_status("idle_push", 2'd1, 1'b0, 1'b0, 4'd1, 2'd0, 4'd0, 8'h00, 8'h00, 8'h00);

    for (int t = 0; t < 6; t++) begin
      care_mask = vecs[t].mask;
      begin_run(1'b1);
      for (int c = 0; c < vecs[t].n + vecs[t].skew1; c++) begin
        logic [2:0] v;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        int         c1;
        c1   = c - vecs[t].skew1;
        v[0] = vecs[t].act[0] && (c < vecs[t].n);
        v[1] = vecs[t].act[1] && (c1 >= 0) && (c1 < vecs[t].n);
        v[2] = vecs[t].act[2] && (c < vecs[t].n);
        w0   = vecs[t].base + 8'(c);
        w1   = vecs[t].base + 8'(c1);
        w2   = vecs[t].base + 8'(c);
        if (vecs[t].bad2 && c == 3) w2 = w2 ^ 8'h01;
        push_cycle(v, w0, w1, w2);
      end
      drain(vecs[t].name);
      check_status(vecs[t].name, vecs[t].e_state, vecs[t].e_div, vecs[t].e_ovf, vecs[t].e_cnt,
                   vecs[t].e_idx, vecs[t].e_fcyc, vecs[t].e_fmask, vecs[t].e_tref, vecs[t].e_tdut);
    end

    // Two instances diverge at once: lowest index reported, masks ORed.
    care_mask = 8'hFF;
    begin_run(1'b1);
    push_cycle(3'b111, 8'h00, 8'hF0, 8'h0F);
    drain("dual");
    check_status("dual", 2'd2, 1'b1, 1'b0, 4'd1, 2'd1, 4'd0, 8'hFF, 8'h00, 8'hF0);

    // Pushes in a terminal state are dropped and nothing is counted.
    model_on = 1'b0;
    push_cycle(3'b111, 8'h01, 8'h01, 8'h01);
    push_cycle(3'b111, 8'h02, 8'h02, 8'h02);
    check("terminal.cmp_cnt", 32'(cmp_cnt), 32'd1);

    clear = 1'b1;
    arm   = 1'b1;
    tick();
    clear = 1'b0;
    check_status("clear_arm", 2'd0, 1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 8'h00, 8'h00, 8'h00);
    tick();
    arm = 1'b0;
    check("rearm.state", 32'(state), 32'd1);
    model_reset();
    push_cycle(3'b111, 8'h07, 8'h07, 8'h07);
    push_cycle(3'b111, 8'h08, 8'h08, 8'h08);
    drain("rearm");
    check("rearm.cmp_cnt", 32'(cmp_cnt), 32'd2);

    // Asynchronous reset lands between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.state", 32'(state), 32'd0);
    check("async_rst.cmp_cnt", 32'(cmp_cnt), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
